// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer: gathers a 64-sample raster block into the DCT H inputs,
// fires dct_start, captures the D outputs after DCT_LATENCY cycles and streams
// them out over valid/ready.
// Build option: DCT_SEQ_ZIGZAG_EN selects JPEG zigzag output order; undefined
// gives raster order.
module dct_block_sequencer #(
  parameter int unsigned DW          = 16,
  parameter int unsigned DCT_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [64*DW-1:0] h_flat,
  output logic             dct_start,
  input  logic [64*DW-1:0] d_flat,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] block_count
);

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  state_e           r_state, w_state_next;
  logic [5:0]       r_idx, r_k, w_order;
  logic [7:0]       r_lat;
  logic [DW-1:0]    r_h   [64];
  logic [DW-1:0]    r_cap [64];
  logic             r_dct_start;
  logic [CNT_W-1:0] r_block_count;
  logic             w_in_fire, w_out_fire;

`ifdef DCT_SEQ_ZIGZAG_EN
  // Zigzag table packed as 64 six-bit entries, built by walking the
  // anti-diagonals with alternating direction.
  function automatic logic [383:0] gen_zigzag();
    logic [383:0] t;
    int n, r, c;
    t = '0;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 8; j++) begin
        r = (s % 2 == 1) ? j : 7 - j;
        c = s - r;
        if (c >= 0 && c < 8) begin
          t[6*n +: 6] = 6'(8 * r + c);
          n++;
        end
      end
    end
    return t;
  endfunction

  localparam logic [383:0] ZigZag = gen_zigzag();

  // Output index -> capture slot, zigzag scan.
  always_comb w_order = ZigZag[6*r_k +: 6];
`else
  // Output index -> capture slot, raster scan.
  always_comb w_order = r_k;
`endif

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StLoad;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StLoad:    if (w_in_fire && r_idx == 6'd63) w_state_next = StCompute;
      StCompute: if (r_lat == 8'd0) w_state_next = StUnload;
      StUnload:  if (w_out_fire && r_k == 6'd63) w_state_next = StLoad;
      default:   w_state_next = StLoad;
    endcase
  end

  // FSM-decoded outputs; in_ready stays low while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      StLoad:    in_ready = ~rst;
      StCompute: busy = 1'b1;
      StUnload: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
    out_last = (r_state == StUnload) && (r_k == 6'd63);
  end

  // Datapath: H loading, latency countdown, D capture and unload indexing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx         <= '0;
      r_k           <= '0;
      r_lat         <= '0;
      r_dct_start   <= 1'b0;
      r_block_count <= '0;
      for (int i = 0; i < 64; i++) begin
        r_h[i]   <= '0;
        r_cap[i] <= '0;
      end
    end else begin
      r_dct_start <= 1'b0;
      case (r_state)
        StLoad: begin
          if (w_in_fire) begin
            r_h[r_idx] <= in_data;
            r_idx      <= r_idx + 6'd1;  // wraps to 0 after slot 63
            if (r_idx == 6'd63) begin
              r_dct_start <= 1'b1;
              r_lat       <= 8'(DCT_LATENCY);
            end
          end
        end
        StCompute: begin
          if (r_lat == 8'd0) begin
            for (int i = 0; i < 64; i++) r_cap[i] <= d_flat[DW*i +: DW];
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end
        StUnload: begin
          if (w_out_fire) begin
            r_k <= r_k + 6'd1;
            if (r_k == 6'd63) r_block_count <= r_block_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the H registers onto the DCT input bus.
  always_comb begin
    h_flat = '0;
    for (int i = 0; i < 64; i++) h_flat[DW*i +: DW] = r_h[i];
  end

  assign dct_start   = r_dct_start;
  assign out_data    = r_cap[w_order];
  assign block_count = r_block_count;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Scoreboard bench for dct_block_sequencer with a latency-exact DCT stub.
module tb_dct_block_sequencer;
  localparam int DW  = 16;
  localparam int LAT = 4;
  localparam int CW  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [64*DW-1:0] h_flat;
  logic             dct_start;
  logic [64*DW-1:0] d_flat = '0;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic [CW-1:0]    block_count;

  dct_block_sequencer #(.DW(DW), .DCT_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .h_flat(h_flat), .dct_start(dct_start), .d_flat(d_flat), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .block_count(block_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ord [64];
  logic [DW-1:0]    smp [64];
  logic [DW:0]      exp_q [$];
  logic [64*DW-1:0] h_q [$];
  bit stub_ident = 1'b1;
  bit bp_k5 = 1'b0;
  bit rnd_ready = 1'b0;
  int mon_k = 0;
  int hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected normal progress", name);
  endtask

  // DCT stub: correct result only in the cycle exactly LAT after dct_start.
  int sc = 0;
  always @(posedge clk) begin
    if (dct_start === 1'b1) sc = 1;
    else if (sc != 0 && sc < LAT + 3) sc = sc + 1;
    else sc = 0;
    for (int i = 0; i < 64; i++)
      d_flat[DW*i +: DW] <= (sc == LAT)
          ? (stub_ident ? DW'(i) : DW'(h_flat[DW*i +: DW] + DW'(3 * i)))
          : DW'($urandom);
  end

  // Consumer ready generation.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_k5 && mon_k == 5 && hold < 10) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks timing.
  bit prev_stall = 0, prev_valid = 0, prev_dct = 0, last_hs = 0;
  logic [DW:0] prev_out;
  int since = 0;
  logic [CW-1:0] exp_bc = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; prev_valid = 0; prev_dct = 0; last_hs = 0;
      since = 0; exp_bc = '0; mon_k = 0;
    end else begin
      if (last_hs) check("block_count", 64'(block_count), 64'(exp_bc));
      last_hs = 0;
      if (dct_start) begin
        check("dct_start_single_pulse", 64'(prev_dct), 64'd0);
        check("in_ready_low_at_start", 64'(in_ready), 64'd0);
        if (h_q.size() == 0) begin
          fail_now("unexpected_dct_start");
        end else begin
          logic [64*DW-1:0] eh;
          eh = h_q.pop_front();
          for (int i = 0; i < 64; i++)
            check($sformatf("h_slot_%0d", i), 64'(h_flat[DW*i +: DW]), 64'(eh[DW*i +: DW]));
        end
        since = 0;
      end else begin
        since++;
      end
      if (busy && in_valid) check("in_ready_while_busy", 64'(in_ready), 64'd0);
      if (out_valid && !prev_valid) begin
        check("first_out_latency", 64'(since), 64'(LAT + 1));
        check("busy_in_unload", 64'(busy), 64'd1);
      end
      if (prev_stall) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_data_held", 64'({out_last, out_data}), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check($sformatf("out_k%0d", mon_k), 64'({out_last, out_data}), 64'(e));
        end
        mon_k++;
        if (out_last) begin
          exp_bc = exp_bc + 1'b1;
          last_hs = 1;
          mon_k = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
      prev_valid = out_valid;
      prev_dct   = dct_start;
    end
  end

  task automatic reset_checks();
    check("rst_h_flat_zero", 64'(h_flat == '0), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_dct_start", 64'(dct_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_block_count", 64'(block_count), 64'd0);
  endtask

  // Drive smp[] as one block; gap 0 = continuous, 1 = alternate, 2 = random.
  // abort_at >= 0 asserts reset instead of presenting that sample.
  task automatic send_block(input int gap, input int abort_at);
    int n = 0, waitc = 0;
    bit tog = 1'b1, vld;
    logic [64*DW-1:0] hp;
    while (n < 64) begin
      @(negedge clk);
      if (n == abort_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        return;
      end
      vld = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      in_valid = vld;
      in_data  = smp[n];
      if (vld && in_ready) n++;
      waitc++;
      if (waitc > 2000) begin
        fail_now("input_timeout");
        return;
      end
    end
    for (int i = 0; i < 64; i++) hp[DW*i +: DW] = smp[i];
    h_q.push_back(hp);
    for (int k = 0; k < 64; k++) begin
      int o;
      o = ord[k];
      exp_q.push_back({k == 63, stub_ident ? DW'(o) : DW'(smp[o] + DW'(3 * o))});
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_smp();
    for (int i = 0; i < 64; i++) smp[i] = DW'($urandom);
  endtask

  initial begin
    int r, c;
`ifdef DCT_SEQ_ZIGZAG_EN
    // Reference zigzag: bounce between edges along anti-diagonals.
    r = 0; c = 0;
    for (int k = 0; k < 64; k++) begin
      ord[k] = 8 * r + c;
      if ((r + c) % 2 == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
`else
    r = 0; c = 0;
    for (int k = 0; k < 64; k++) ord[k] = k;
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Constant 28.0 block, identity stub.
    for (int i = 0; i < 64; i++) smp[i] = 16'h1C00;
    stub_ident = 1'b1;
    send_block(0, -1);
    wait_drain();
    check("block_count_after_first", 64'(block_count), 64'd1);

    // Backpressure at k=5 for ten cycles.
    stub_ident = 1'b0;
    rand_smp();
    hold = 0;
    bp_k5 = 1'b1;
    send_block(0, -1);
    wait_drain();
    bp_k5 = 1'b0;
    check("bp_hold_cycles", 64'(hold), 64'd10);

    // Alternating input gaps, back-to-back blocks (in_valid high during unload).
    rand_smp();
    send_block(1, -1);
    rand_smp();
    send_block(1, -1);
    wait_drain();

    // Reset at the 30th sample, then a fresh block.
    rand_smp();
    send_block(0, 29);
    rand_smp();
    send_block(0, -1);
    wait_drain();
    check("block_count_after_abort", 64'(block_count), 64'd1);

    // Random gaps and random consumer stalls.
    rnd_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rand_smp();
      send_block(2, -1);
    end
    wait_drain();
    rnd_ready = 1'b0;

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("h_queue_empty", 64'(h_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
